// File: rtl/edge_delay_if.sv
// edge_delay_if: stimulus/response nets, expected delays and measurement results
//   master: bench side, drives trig/resp/resp_en/exp_*, observes results
//   slave : monitor side, samples inputs, drives meas_*/busy/statistics
interface edge_delay_if #(
  parameter int CNT_W  = 8,
  parameter int STAT_W = 16
);
  logic              trig;
  logic              resp;
  logic              resp_en;
  logic [CNT_W-1:0]  exp_rise;
  logic [CNT_W-1:0]  exp_fall;
  logic [CNT_W-1:0]  exp_off;
  logic              meas_valid;
  logic [1:0]        meas_type;
  logic [CNT_W-1:0]  meas_cnt;
  logic              meas_viol;
  logic              meas_abort;
  logic              busy;
  logic [STAT_W-1:0] total_cnt;
  logic [STAT_W-1:0] viol_cnt;
  modport master (
    output trig, resp, resp_en, exp_rise, exp_fall, exp_off,
    input  meas_valid, meas_type, meas_cnt, meas_viol, meas_abort, busy, total_cnt, viol_cnt
  );
  modport slave (
    input  trig, resp, resp_en, exp_rise, exp_fall, exp_off,
    output meas_valid, meas_type, meas_cnt, meas_viol, meas_abort, busy, total_cnt, viol_cnt
  );
endinterface

// File: rtl/edge_delay_monitor.sv
// edge_delay_monitor: cycles from each trig edge to the next gate response change
//   clk, rst_n (sync, active-low)
//   bus.slave: trig/resp/resp_en/exp_* in; meas_valid/type/cnt/viol/abort, busy,
//              total_cnt/viol_cnt (saturating) out
module edge_delay_monitor #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255,
  parameter int STAT_W  = 16
) (
  input logic         clk,
  input logic         rst_n,
  edge_delay_if.slave bus
);
  typedef enum logic {IDLE, ARMED} state_t;
  state_t state;
  logic trig_q, trig_qq, resp_q, resp_qq, en_q, en_qq;
  logic [1:0] pv;
  logic [CNT_W-1:0] cnt, cnt_n, lr, lf, lo, rcnt, rexp;
  logic trig_edge, resp_chg, tmo, rep, viol;
  logic [1:0] typ;
  // pv[1] is set only once both _q and _qq hold real post-reset samples,
  // so a level held across reset never looks like an edge
  always_comb begin
    trig_edge = pv[1] & (trig_q ^ trig_qq);
    resp_chg  = pv[1] & ((en_q ^ en_qq) | (en_q & (resp_q ^ resp_qq)));
    cnt_n     = cnt + 1'b1;
    tmo       = (state == ARMED) && !resp_chg && !trig_edge && (cnt_n == CNT_W'(TIMEOUT));
    rep       = ((state == ARMED) && resp_chg) || tmo;
    typ       = tmo ? 2'b11 : !en_q ? 2'b10 : resp_q ? 2'b00 : 2'b01;
    rcnt      = tmo ? CNT_W'(TIMEOUT) : cnt_n;
    rexp      = (typ == 2'b00) ? lr : (typ == 2'b01) ? lf : lo;
    viol      = tmo | (rcnt != rexp);
  end
  assign bus.busy = (state == ARMED);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      {trig_q, resp_q, en_q, trig_qq, resp_qq, en_qq} <= '0;
      pv             <= '0;
      cnt            <= '0;
      lr             <= '0;
      lf             <= '0;
      lo             <= '0;
      bus.meas_valid <= 1'b0;
      bus.meas_type  <= '0;
      bus.meas_cnt   <= '0;
      bus.meas_viol  <= 1'b0;
      bus.meas_abort <= 1'b0;
      bus.total_cnt  <= '0;
      bus.viol_cnt   <= '0;
    end else begin
      {trig_q, resp_q, en_q}    <= {bus.trig, bus.resp, bus.resp_en};
      {trig_qq, resp_qq, en_qq} <= {trig_q, resp_q, en_q};
      pv             <= {pv[0], 1'b1};
      bus.meas_valid <= rep;
      bus.meas_abort <= (state == ARMED) && trig_edge && !resp_chg;
      if (rep) begin
        bus.meas_type <= typ;
        bus.meas_cnt  <= rcnt;
        bus.meas_viol <= viol;
        if (bus.total_cnt != '1) bus.total_cnt <= bus.total_cnt + 1'b1;
        if (viol && bus.viol_cnt != '1) bus.viol_cnt <= bus.viol_cnt + 1'b1;
      end
      // a trig edge always (re)arms: after completing a report in the same
      // cycle, or discarding the pending measurement otherwise
      if (trig_edge) begin
        state <= ARMED;
        cnt   <= '0;
        lr    <= bus.exp_rise;
        lf    <= bus.exp_fall;
        lo    <= bus.exp_off;
      end else if (rep) begin
        state <= IDLE;
      end else if (state == ARMED) begin
        cnt <= cnt_n;
      end
    end
  end
endmodule

// File: tb/tb_edge_delay_monitor.sv
// tb_edge_delay_monitor: randomized transactions, scoreboard queue, stats model
module tb_edge_delay_monitor;
  localparam int CNT_W = 8, TO = 20, STAT_W = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  edge_delay_if #(.CNT_W(CNT_W), .STAT_W(STAT_W)) bus();
  edge_delay_if #(.CNT_W(CNT_W), .STAT_W(2)) sbus();
  assign sbus.trig     = bus.trig;
  assign sbus.resp     = bus.resp;
  assign sbus.resp_en  = bus.resp_en;
  assign sbus.exp_rise = bus.exp_rise;
  assign sbus.exp_fall = bus.exp_fall;
  assign sbus.exp_off  = bus.exp_off;
  edge_delay_monitor #(.CNT_W(CNT_W), .TIMEOUT(TO), .STAT_W(STAT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  edge_delay_monitor #(.CNT_W(CNT_W), .TIMEOUT(TO), .STAT_W(2)) dut_s (.clk(clk), .rst_n(rst_n), .bus(sbus.slave));
  typedef struct { int t; int c; int v; } exp_t;
  exp_t q[$];
  exp_t e;
  int errs = 0, checks = 0, n_tot = 0, n_viol = 0, ab_exp = 0, ab_seen = 0;
  task automatic chk(string nm, int act, int req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk_zero(string nm);
    chk({nm, "_valid"}, bus.meas_valid, 0);
    chk({nm, "_type"}, bus.meas_type, 0);
    chk({nm, "_cnt"}, bus.meas_cnt, 0);
    chk({nm, "_viol"}, bus.meas_viol, 0);
    chk({nm, "_abort"}, bus.meas_abort, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_total"}, bus.total_cnt, 0);
    chk({nm, "_violcnt"}, bus.viol_cnt, 0);
  endtask
  task automatic push(int t, int c, int ex);
    int v;
    v = (t == 3 || c != ex) ? 1 : 0;
    q.push_back('{t, c, v});
    n_tot++;
    n_viol += v;
  endtask
  // n: cycles from last trig change to response change; k: retrigger after k cycles (0 = none)
  task automatic txn(int n, int k, bit go);
    int er, ef, eo, t, ex;
    logic nr, ne;
    er = $urandom_range(1, TO);
    ef = $urandom_range(1, TO);
    eo = $urandom_range(1, TO);
    if (bus.resp_en && $urandom_range(0, 2) == 0) begin ne = 1'b0; nr = bus.resp; end
    else if (bus.resp_en) begin ne = 1'b1; nr = ~bus.resp; end
    else begin ne = 1'b1; nr = 1'($urandom_range(0, 1)); end
    t = !ne ? 2 : nr ? 0 : 1;
    if ($urandom_range(0, 1) == 1) begin
      if (t == 0) er = n; else if (t == 1) ef = n; else eo = n;
    end
    bus.exp_rise = CNT_W'(er);
    bus.exp_fall = CNT_W'(ef);
    bus.exp_off  = CNT_W'(eo);
    bus.trig = ~bus.trig;
    if (k > 0) begin
      tick(k);
      bus.trig = ~bus.trig;
      ab_exp++;
    end
    ex = (t == 0) ? er : (t == 1) ? ef : eo;
    if (go) push(t, n, ex); else push(3, TO, ex);
    for (int i = 1; i <= (go ? n : TO); i++) begin
      tick(1);
      if (i == 3) begin
        if (!go || n > 3) chk("busy_armed", bus.busy, 1);
        bus.exp_rise = CNT_W'($urandom_range(0, 255));
        bus.exp_fall = CNT_W'($urandom_range(0, 255));
        bus.exp_off  = CNT_W'($urandom_range(0, 255));
      end
    end
    if (go) begin
      bus.resp = nr;
      bus.resp_en = ne;
    end
    tick(6);
    chk("busy_idle", bus.busy, 0);
    chk("total_cnt", bus.total_cnt, n_tot);
    chk("viol_cnt", bus.viol_cnt, n_viol);
    chk("sat_total", sbus.total_cnt, n_tot > 3 ? 3 : n_tot);
    chk("sat_viol", sbus.viol_cnt, n_viol > 3 ? 3 : n_viol);
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.meas_abort) ab_seen++;
      if (bus.meas_valid) begin
        if (q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          e = q.pop_front();
          chk("meas_type", bus.meas_type, e.t);
          chk("meas_cnt", bus.meas_cnt, e.c);
          chk("meas_viol", bus.meas_viol, e.v);
          chk("busy_at_valid", bus.busy, 0);
        end
      end
    end
  end
  initial begin
    bus.trig = 1'b1;
    bus.resp = 1'b0;
    bus.resp_en = 1'b1;
    bus.exp_rise = '0;
    bus.exp_fall = '0;
    bus.exp_off = '0;
    tick(3);
    chk_zero("reset");
    rst_n = 1'b1;
    tick(10);
    chk("prime_busy", bus.busy, 0);
    bus.trig = 1'b0;
    tick(5);
    chk("pre_reset_busy", bus.busy, 1);
    rst_n = 1'b0;
    tick(2);
    chk_zero("mid_reset");
    rst_n = 1'b1;
    tick(10);
    chk("post_reset_busy", bus.busy, 0);
    chk("post_reset_total", bus.total_cnt, 0);
    txn(2, 0, 1'b1);
    txn(1, 0, 1'b1);
    txn(TO, 0, 1'b1);
    txn(7, 0, 1'b0);
    txn(3, 2, 1'b1);
    txn(4, 1, 1'b1);
    for (int i = 0; i < 40; i++)
      txn($urandom_range(1, TO), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0, $urandom_range(0, 7) != 0);
    for (int i = 0; i < 100 && q.size() > 0; i++) tick(1);
    chk("queue_drained", q.size(), 0);
    chk("abort_count", ab_seen, ab_exp);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/edge_delay_monitor.md
Name: edge_delay_monitor

Overview:
- Clocked measurement stage that sits directly downstream of the gate-delay primitives (and, bufif0).
- Watches a stimulus net and the gate's response net plus its drive-enable.
- Counts clock cycles from each stimulus edge to the next response transition, then classifies the transition as rise, fall, turn-off or timeout.
- Compares each count to a programmed expected delay and keeps saturating pass/violation statistics for the bench.

Parameters:
- CNT_W, 8, width of delay counter and expected-delay inputs
- TIMEOUT, 255, cycles without response before a timeout is reported; must be between 1 and 2^CNT_W-1
- STAT_W, 16, width of saturating statistics counters

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- trig  in  1  stimulus level (gate input under test)
- resp  in  1  gate output data value, meaningful when resp_en=1
- resp_en  in  1  1 = output driven, 0 = high-Z (turned off)
- exp_rise  in  CNT_W  expected rise delay, cycles
- exp_fall  in  CNT_W  expected fall delay, cycles
- exp_off  in  CNT_W  expected turn-off delay, cycles
- meas_valid  out  1  one-cycle pulse, result fields valid
- meas_type  out  2  00 rise, 01 fall, 10 turn-off, 11 timeout
- meas_cnt  out  CNT_W  measured delay, cycles
- meas_viol  out  1  measured delay differs from expected, or timeout
- meas_abort  out  1  one-cycle pulse, measurement discarded by retrigger
- busy  out  1  measurement in progress (ARMED)
- total_cnt  out  STAT_W  completed measurements, saturating
- viol_cnt  out  STAT_W  violations, saturating

Behaviour:
- Reset (rst_n=0 at posedge): all outputs 0. FSM goes to IDLE. Sample registers and counters are cleared.
- Reset mid-measurement: the measurement is dropped silently, with no meas_valid and no meas_abort.
- Sampling: trig, resp and resp_en pass through the same two-register pipeline (_q, _qq), so relative timing is preserved.
- Edge detection:
  - trig_edge = trig_q ^ trig_qq.
  - resp_chg = (resp_q,resp_en_q) != (resp_qq,resp_en_qq), where resp is ignored whenever both enables are 0.
- Prime rule: on the first cycle after reset deassertion, the _qq registers load from _q and edge detection is suppressed. A constant-high input therefore raises no false edge.
- Classification of resp_chg:
  - resp_en 1->0: turn-off.
  - resp_en 0->1 with resp=1, or resp 0->1 with resp_en=1: rise.
  - resp_en 0->1 with resp=0, or resp 1->0 with resp_en=1: fall.
- FSM states: IDLE, ARMED.
  - IDLE + trig_edge: go to ARMED, cnt=0, and latch exp_rise/exp_fall/exp_off. Later changes to the exp_* inputs do not affect this measurement.
  - IDLE + resp_chg without trig_edge: ignored.
  - IDLE + trig_edge and resp_chg in the same cycle: the response belongs to no measurement; enter ARMED normally.
  - ARMED, each cycle: cnt <= cnt+1.
  - ARMED + resp_chg: report with meas_cnt = cnt+1, i.e. cycles from edge-detect cycle to change-detect cycle. Go to IDLE unless trig_edge is also present.
  - ARMED + trig_edge, no resp_chg: pulse meas_abort, restart with cnt=0 and re-latch the exp_* values. This is inertial: the old measurement is discarded.
  - ARMED + trig_edge and resp_chg together: complete the current measurement first, then re-arm (stay ARMED, cnt=0, re-latch).
  - ARMED + cnt+1 == TIMEOUT, no resp_chg: report type 11, meas_cnt=TIMEOUT, meas_viol=1, go to IDLE.
- Reporting: result outputs are registered. meas_valid is asserted the cycle after the decision, for exactly one cycle. meas_type, meas_cnt and meas_viol hold until the next report.
- meas_viol: meas_cnt != latched expected value for the reported type; timeout always sets it.
- Statistics: total_cnt increments on every meas_valid; viol_cnt increments on meas_valid with meas_viol=1. Both saturate at 2^STAT_W-1 and are cleared only by reset.
- busy = (state == ARMED).
- End-to-end latency: a trig change is seen as trig_edge 2 cycles later. A response change N cycles after the trig change gives meas_cnt=N, and meas_valid appears N+3 cycles after the trig change.

Test Plan:
- rise: exp_rise=2. Drive trig 0->1 at cycle 10 and resp 0->1 (en=1) at cycle 12 -> meas_valid at cycle 13+2, type 00, meas_cnt=2, meas_viol=0, total_cnt=1.
- fall violation: exp_fall=3. Drive trig 1->0, then resp 1->0 five cycles later -> type 01, meas_cnt=5, meas_viol=1, viol_cnt=1.
- turn-off: exp_off=7. Drive trig edge, then resp_en 1->0 seven cycles later -> type 10, meas_cnt=7, meas_viol=0. A following resp_en 0->1 with resp=1 after a new trig edge -> type 00.
- retrigger: trig edge, then a second trig edge 2 cycles later, then resp change 3 cycles after the second edge -> meas_abort pulses once, then meas_cnt=3. total_cnt increments by 1 only.
- timeout: TIMEOUT=20, trig edge with no response -> after 20 cycles, type 11, meas_cnt=20, meas_viol=1. busy drops the cycle after the decision.
- reset/prime: hold trig=1 through reset, then assert rst_n=0 in the middle of an ARMED measurement -> no meas_valid, no false edge after release, all outputs 0. total_cnt saturation is checked with STAT_W=2: four measurements -> total_cnt=3.
